// File: rtl/debounce_pkg.sv
// Shared types for the debounce scheduler: scan FSM states and the event record.
package debounce_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } sched_state_t;

   localparam int EVT_ID_MAX_W = 8;

   typedef struct packed {
      logic [EVT_ID_MAX_W-1:0] id;
      logic                    level;
   } deb_event_t;

   function automatic int id_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/debounce_prescaler.sv
// Sample-tick generator: free-running 0..PRESCALER-1 counter, held at 0 while disabled.
module debounce_prescaler #(
   parameter int PRESCALER = 16
) (
   input  logic aclk,
   input  logic srst,
   input  logic enable,
   output logic tick
);

   localparam int PW = (PRESCALER <= 1) ? 1 : $clog2(PRESCALER);
   localparam logic [PW-1:0] LAST = PW'(PRESCALER - 1);

   logic [PW-1:0] cnt;

   assign tick = enable && (cnt == LAST);

   always_ff @(posedge aclk) begin
      if (srst) begin
         cnt <= '0;
      end else if (!enable || (cnt == LAST)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/debounce_scheduler.sv
// Time-multiplexed button debouncer with a single-entry press/release event slot.
// Event slot built only when DEBOUNCE_SCHED_EVENT_EN is defined; otherwise event outputs are 0.
module debounce_scheduler
   import debounce_pkg::*;
#(
   parameter  int NB_BUTTON = 4,
   parameter  int PRESCALER = 16,
   parameter  int DEB_TICKS = 8,
   localparam int ID_W      = id_width(NB_BUTTON),
   localparam int CNT_W     = $clog2(DEB_TICKS + 1)
) (
   input  logic                 aclk,
   input  logic                 srst,
   input  logic                 enable,
   input  logic [NB_BUTTON-1:0] buttons,
   output logic [NB_BUTTON-1:0] debounced,
   output logic                 busy,
   output logic                 evt_valid,
   input  logic                 evt_ready,
   output logic [ID_W-1:0]      evt_id,
   output logic                 evt_level,
   output logic                 evt_overflow,
   input  logic                 ovf_clr
);

   if (PRESCALER < NB_BUTTON + 1) begin : g_bad_prescaler
      $error("PRESCALER must be at least NB_BUTTON+1 so a tick never lands inside a scan");
   end
   if (DEB_TICKS < 2) begin : g_bad_ticks
      $error("DEB_TICKS must be at least 2");
   end
   if (ID_W > EVT_ID_MAX_W) begin : g_bad_width
      $error("NB_BUTTON too large for the event id field");
   end

   localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NB_BUTTON - 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEB_TICKS - 1);

   logic [NB_BUTTON-1:0]            sync_p0, sync_p1;
   logic [NB_BUTTON-1:0][CNT_W-1:0] cnt;
   sched_state_t                    state;
   logic [ID_W-1:0]                 idx;
   logic                            tick;
   logic                            ch_sync, ch_deb, ch_last, flip;
   logic [CNT_W-1:0]                ch_cnt;

   debounce_prescaler #(.PRESCALER(PRESCALER)) u_prescaler (
      .aclk   (aclk),
      .srst   (srst),
      .enable (enable),
      .tick   (tick)
   );

   // Stage p0/p1: two-flop synchroniser on the raw inputs
   always_ff @(posedge aclk) begin
      if (srst) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= buttons;
         sync_p1 <= sync_p0;
      end
   end

   always_comb begin
      ch_sync = sync_p1[idx];
      ch_deb  = debounced[idx];
      ch_cnt  = cnt[idx];
      ch_last = (ch_cnt == LAST_CNT);
      flip    = (state == SCAN) && (ch_sync != ch_deb) && ch_last;
   end

   always_ff @(posedge aclk) begin
      if (srst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         idx       <= '0;
         cnt       <= '0;
         debounced <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (tick) begin
                  state <= SCAN;
                  busy  <= 1'b1;
                  idx   <= '0;
               end
            end
            SCAN: begin
               if (ch_sync == ch_deb) begin
                  cnt[idx] <= '0;
               end else if (ch_last) begin
                  debounced[idx] <= ch_sync;
                  cnt[idx]       <= '0;
               end else begin
                  cnt[idx] <= ch_cnt + 1'b1;
               end
               if (idx == LAST_ID) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  idx   <= '0;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
         endcase
      end
   end

`ifdef DEBOUNCE_SCHED_EVENT_EN
   deb_event_t evt_q, new_ev;
   logic       evt_v, ovf_q;
   logic       unused_evt;

   always_comb begin
      new_ev       = '0;
      new_ev.id    = EVT_ID_MAX_W'(idx);
      new_ev.level = ch_sync;
   end

   // A flip is never held back: when the slot is full and not draining, the event is lost
   always_ff @(posedge aclk) begin
      if (srst) begin
         evt_v <= 1'b0;
         evt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         if (flip && (!evt_v || evt_ready)) begin
            evt_v <= 1'b1;
            evt_q <= new_ev;
         end else if (evt_v && evt_ready) begin
            evt_v <= 1'b0;
         end
         if (flip && evt_v && !evt_ready) begin
            ovf_q <= 1'b1;
         end else if (ovf_clr) begin
            ovf_q <= 1'b0;
         end
      end
   end

   assign evt_valid    = evt_v;
   assign evt_id       = evt_q.id[ID_W-1:0];
   assign evt_level    = evt_q.level;
   assign evt_overflow = ovf_q;
   assign unused_evt   = ^evt_q.id;
`else
   logic unused_evt;

   assign evt_valid    = 1'b0;
   assign evt_id       = '0;
   assign evt_level    = 1'b0;
   assign evt_overflow = 1'b0;
   assign unused_evt   = ^{evt_ready, ovf_clr, flip};
`endif

endmodule

// File: tb/tb_debounce_scheduler.sv
// Randomised and directed bench for debounce_scheduler against a behavioural model.
module tb_debounce_scheduler;

   localparam int NB = 4;
   localparam int P  = 16;
   localparam int D  = 8;
`ifdef DEBOUNCE_SCHED_EVENT_EN
   localparam bit EVT_EN = 1'b1;
`else
   localparam bit EVT_EN = 1'b0;
`endif

   logic          aclk = 1'b0;
   logic          srst, enable, evt_ready, ovf_clr;
   logic [NB-1:0] buttons, debounced;
   logic          busy, evt_valid, evt_level, evt_overflow;
   logic [1:0]    evt_id;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   bit chk_on = 1'b1;

   // behavioural model state
   bit m_s1[NB], m_s2[NB], m_deb[NB];
   int m_cnt[NB];
   int m_pre, m_sidx, m_ev_id;
   bit m_scan, m_ev_v, m_ev_lvl, m_ovf;
   bit t_tick, t_flip, t_pop, t_drop, t_lvl;
   int t_id;

   int ev_id_q[$];
   int ev_lvl_q[$];

   always #5 aclk = ~aclk;

   debounce_scheduler #(.NB_BUTTON(NB), .PRESCALER(P), .DEB_TICKS(D)) dut (
      .aclk         (aclk),
      .srst         (srst),
      .enable       (enable),
      .buttons      (buttons),
      .debounced    (debounced),
      .busy         (busy),
      .evt_valid    (evt_valid),
      .evt_ready    (evt_ready),
      .evt_id       (evt_id),
      .evt_level    (evt_level),
      .evt_overflow (evt_overflow),
      .ovf_clr      (ovf_clr)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference: each tick opens a scan window of NB cycles, channel k sampled in its k-th cycle
   always @(posedge aclk) begin
      cyc++;
      if (evt_valid && evt_ready) begin
         ev_id_q.push_back(int'(evt_id));
         ev_lvl_q.push_back(int'(evt_level));
      end
      if (srst) begin
         for (int i = 0; i < NB; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_cnt[i] = 0;
         end
         m_pre = 0; m_sidx = 0; m_scan = 0;
         m_ev_v = 0; m_ev_id = 0; m_ev_lvl = 0; m_ovf = 0;
      end else begin
         t_flip = 0;
         t_tick = enable && (m_pre == P - 1);
         m_pre  = enable ? (m_pre + 1) % P : 0;
         if (m_scan) begin
            t_id = m_sidx;
            if (m_s2[t_id] == m_deb[t_id]) begin
               m_cnt[t_id] = 0;
            end else if (m_cnt[t_id] + 1 == D) begin
               m_deb[t_id] = m_s2[t_id];
               m_cnt[t_id] = 0;
               t_flip = 1;
               t_lvl  = m_s2[t_id];
            end else begin
               m_cnt[t_id]++;
            end
            m_sidx++;
            if (m_sidx == NB) begin
               m_scan = 0;
               m_sidx = 0;
            end
         end else if (t_tick) begin
            m_scan = 1;
            m_sidx = 0;
         end
         t_pop  = m_ev_v && evt_ready;
         t_drop = t_flip && m_ev_v && !evt_ready;
         if (t_pop) m_ev_v = 0;
         if (t_flip && !t_drop) begin
            m_ev_v = 1; m_ev_id = t_id; m_ev_lvl = t_lvl;
         end
         if (t_drop) m_ovf = 1;
         else if (ovf_clr) m_ovf = 0;
         for (int i = 0; i < NB; i++) begin
            m_s2[i] = m_s1[i];
            m_s1[i] = buttons[i];
         end
      end
   end

   always @(negedge aclk) begin
      logic [NB-1:0] exp_deb;
      if (chk_on) begin
         for (int i = 0; i < NB; i++) exp_deb[i] = m_deb[i];
         chk("model_debounced", debounced, exp_deb);
         chk("model_busy", busy, m_scan);
         chk("model_evt_valid", evt_valid, EVT_EN ? m_ev_v : 1'b0);
         chk("model_evt_overflow", evt_overflow, EVT_EN ? m_ovf : 1'b0);
         if (EVT_EN && m_ev_v) begin
            chk("model_evt_id", evt_id, m_ev_id);
            chk("model_evt_level", evt_level, m_ev_lvl);
         end
      end
   end

   task automatic wait_level(input int ch, input logic lvl, output int lat);
      int t0;
      t0 = cyc;
      while (debounced[ch] !== lvl && (cyc - t0) < 200) @(negedge aclk);
      lat = cyc - t0;
   endtask

   initial begin
      int lat;
      int guard;
      srst = 1'b1; enable = 1'b1; buttons = 4'hF; evt_ready = 1'b1; ovf_clr = 1'b0;

      // 1: reset with buttons high, then idle low
      repeat (10) @(negedge aclk);
      chk("t1_rst_debounced", debounced, 4'h0);
      chk("t1_rst_evt_valid", evt_valid, 1'b0);
      chk("t1_rst_busy", busy, 1'b0);
      srst = 1'b0; buttons = 4'h0;
      repeat (300) @(negedge aclk);
      chk("t1_no_event", ev_id_q.size(), 0);
      chk("t1_debounced", debounced, 4'h0);

      // 2: press channel 2
      ev_id_q.delete(); ev_lvl_q.delete();
      buttons[2] = 1'b1;
      wait_level(2, 1'b1, lat);
      chk("t2_latency_in_window", (lat >= 112 && lat <= 135), 1'b1);
      repeat (20) @(negedge aclk);
      chk("t2_event_count", ev_id_q.size(), EVT_EN ? 1 : 0);
      if (ev_id_q.size() > 0) begin
         chk("t2_event_id", ev_id_q[0], 2);
         chk("t2_event_level", ev_lvl_q[0], 1);
      end

      // 5: release channel 2
      ev_id_q.delete(); ev_lvl_q.delete();
      buttons[2] = 1'b0;
      wait_level(2, 1'b0, lat);
      chk("t5_release_latency", (lat <= 135), 1'b1);
      repeat (20) @(negedge aclk);
      chk("t5_event_count", ev_id_q.size(), EVT_EN ? 1 : 0);
      if (ev_id_q.size() > 0) begin
         chk("t5_event_id", ev_id_q[0], 2);
         chk("t5_event_level", ev_lvl_q[0], 0);
      end

      // 3: bouncing channel 1 never settles long enough
      ev_id_q.delete(); ev_lvl_q.delete();
      for (int k = 0; k < 10; k++) begin
         buttons[1] = ~buttons[1];
         repeat (40) @(negedge aclk);
      end
      repeat (150) @(negedge aclk);
      chk("t3_debounced1", debounced[1], 1'b0);
      chk("t3_no_event", ev_id_q.size(), 0);
      chk("t3_overflow", evt_overflow, 1'b0);

      // 4: two simultaneous presses into a stalled slot
      evt_ready = 1'b0;
      buttons[0] = 1'b1; buttons[3] = 1'b1;
      repeat (200) @(negedge aclk);
      chk("t4_debounced", debounced, 4'b1001);
      chk("t4_evt_valid", evt_valid, EVT_EN);
      chk("t4_evt_overflow", evt_overflow, EVT_EN);
      if (EVT_EN) begin
         chk("t4_evt_id", evt_id, 2'd0);
         chk("t4_evt_level", evt_level, 1'b1);
      end
      evt_ready = 1'b1;
      @(negedge aclk);
      evt_ready = 1'b0;
      chk("t4_popped", evt_valid, 1'b0);
      chk("t4_overflow_sticky", evt_overflow, EVT_EN);
      ovf_clr = 1'b1;
      @(negedge aclk);
      ovf_clr = 1'b0;
      chk("t4_overflow_cleared", evt_overflow, 1'b0);
      evt_ready = 1'b1;

      // 6: reset part-way through a press
      buttons[1] = 1'b1;
      guard = 0;
      while (m_cnt[1] != 5 && guard < 200) begin
         @(negedge aclk);
         guard++;
      end
      chk("t6_reached_count5", (guard < 200), 1'b1);
      srst = 1'b1;
      @(negedge aclk);
      srst = 1'b0;
      chk("t6_debounced", debounced, 4'h0);
      chk("t6_evt_valid", evt_valid, 1'b0);
      chk("t6_busy", busy, 1'b0);
      wait_level(1, 1'b1, lat);
      chk("t6_full_relatency", (lat >= 112 && lat <= 135), 1'b1);

      // random phase
      for (int k = 0; k < 3000; k++) begin
         @(negedge aclk);
         srst      = ($urandom_range(1499) == 0);
         evt_ready = ($urandom_range(3) != 0);
         ovf_clr   = ($urandom_range(49) == 0);
         if ($urandom_range(299) == 0) enable = ~enable;
         if ($urandom_range(59) == 0) buttons[$urandom_range(NB-1)] ^= 1'b1;
      end
      srst = 1'b0;
      @(negedge aclk);
      chk_on = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
